ldl_sfifo_v2: RTL and testbench
===============================

Name: ldl_sfifo_v2

Overview:
- Single-clock synchronous FIFO; next generation of the team's sfifo.
- Generalised to any depth, not only powers of two, with non-binary pointer wrap.
- Selectable first-word-fall-through (FWFT) or registered-read output mode.
- Adds programmable almost-full/almost-empty flags, exact occupancy count, synchronous flush, and overflow/underflow pulses. Used as general stream buffering between pipeline stages.

Parameters:
- DW, 8, data width in bits.
- DEPTH, 16, number of entries; any integer >= 2.
- AW, $clog2(DEPTH), pointer width; derived, never overridden.
- FWFT, 1: 1 = head word presented on dout while not empty; 0 = dout loaded one cycle after an accepted read.
- AF_LVL, DEPTH-2, afull asserts when count >= AF_LVL; legal range 1..DEPTH.
- AE_LVL, 2, aempty asserts when count <= AE_LVL; legal range 0..DEPTH-1.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset, asynchronous assert, active-low (0 = reset); released synchronously by the source.
- clr  in  1  synchronous flush.
- we  in  1  write request.
- din  in  DW  write data.
- re  in  1  read request.
- dout  out  DW  read data.
- dvld  out  1  dout valid.
- empty  out  1  count == 0.
- full  out  1  count == DEPTH.
- aempty  out  1  count <= AE_LVL.
- afull  out  1  count >= AF_LVL.
- cnt  out  AW+1  occupancy, 0..DEPTH.
- ovf  out  1  one-cycle pulse: write rejected.
- udf  out  1  one-cycle pulse: read rejected.

Behaviour:
- Reset (rst=0), asynchronous: wr/rd pointers=0, cnt=0, empty=1, full=0, aempty=1, afull=0, dout=0, dvld=0, ovf=0, udf=0. Storage array is not cleared, and no pre-reset data is ever readable after reset. Reset mid-burst discards all contents.
- Write accepted iff we && !full; storage[wp] <= din; wp wraps DEPTH-1 -> 0.
- Write with full=1 is rejected, even when a read is accepted in the same cycle; ovf=1 in the next cycle.
- Read accepted iff re && !empty; rp wraps DEPTH-1 -> 0.
- Read with empty=1 is rejected, even when a write is accepted in the same cycle; udf=1 in the next cycle.
- Simultaneous accepted read and write: cnt is unchanged and both pointers advance.
- cnt is a register. All flags are registered functions of the next cnt, so every flag is exact in the cycle after the edge that caused the change. No combinational input-to-flag paths.
- FWFT=1:
  - dvld = !empty; dout = head entry whenever empty=0.
  - A write into an empty FIFO at edge N is visible on dout from cycle N+1.
  - An accepted read at edge N presents the next entry from N+1.
  - When empty, dout holds the last value.
- FWFT=0:
  - An accepted read at edge N loads dout with the head and sets dvld=1 for exactly cycle N+1.
  - dout holds otherwise; read latency is 1 cycle.
- clr=1: pointers=0, cnt=0, flags as at reset, dvld=0, dout holds. clr has priority over we/re, and writes/reads in that cycle are dropped silently with no ovf/udf.
- Illegal parameter values (DEPTH<2, AF_LVL or AE_LVL out of range) are stopped by elaboration-time assertions.
- Storage is inferred as a 2-port array: synchronous write, read through a registered output.

Test Plan:
- DEPTH=5, FWFT=1: write 0x11..0x55 in 5 back-to-back cycles -> cnt=5, full=1, afull=1 from AF_LVL=3 onward; 6th write 0x66 -> ovf pulse, cnt stays 5; 5 reads return 0x11..0x55 in order, then empty=1.
- DEPTH=5 wrap: 7 write+pop cycles at cnt=2 -> pointers wrap past 4 to 0 and order is preserved (0xA0..0xA6); cnt stays 2 throughout.
- FWFT=0: write 0x3C, then re in the next cycle -> dout=0x3C with dvld=1 one cycle after the read, dvld=0 the following cycle.
- Empty FIFO with re=1 and we=1 together -> read rejected with udf pulse, write accepted, cnt=1, empty=0 next cycle.
- Full FIFO with re=1 and we=1 together -> read accepted, write rejected with ovf pulse, cnt=DEPTH-1.
- Fill to 3, assert clr with we=1 -> cnt=0, empty=1, aempty=1, no ovf/udf. Then pull rst low mid-burst -> all outputs immediately at reset values without a clock edge.

Source files
------------

// File: rtl/ldl_sfifo_v2_if.sv
// Stream-side port bundle of ldl_sfifo_v2: write/read handshakes, data, status flags.
// The master drives requests, the slave (the FIFO) drives data and status.
interface ldl_sfifo_v2_if #(
  parameter int DW    = 8,
  parameter int DEPTH = 16
);
  localparam int AW = $clog2(DEPTH);

  logic          clr;
  logic          we;
  logic [DW-1:0] din;
  logic          re;
  logic [DW-1:0] dout;
  logic          dvld;
  logic          empty;
  logic          full;
  logic          aempty;
  logic          afull;
  logic [AW:0]   cnt;
  logic          ovf;
  logic          udf;

  modport master (
    output clr, we, din, re,
    input  dout, dvld, empty, full, aempty, afull, cnt, ovf, udf
  );

  modport slave (
    input  clr, we, din, re,
    output dout, dvld, empty, full, aempty, afull, cnt, ovf, udf
  );
endinterface

// File: rtl/ldl_sfifo_v2.sv
// Single-clock FIFO of any depth, with FWFT or registered-read output, registered
// occupancy/flags, synchronous flush and overflow/underflow pulses.
module ldl_sfifo_v2 #(
  parameter int DW     = 8,
  parameter int DEPTH  = 16,
  parameter bit FWFT   = 1'b1,
  parameter int AF_LVL = DEPTH - 2,
  parameter int AE_LVL = 2
) (
  input  logic           clk,
  input  logic           rst,
  ldl_sfifo_v2_if.slave  f
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  generate
    if (DEPTH < 2) begin : g_bad_depth
      $error("ldl_sfifo_v2: DEPTH must be >= 2");
    end
    if (AF_LVL < 1 || AF_LVL > DEPTH) begin : g_bad_af
      $error("ldl_sfifo_v2: AF_LVL out of range 1..DEPTH");
    end
    if (AE_LVL < 0 || AE_LVL > DEPTH - 1) begin : g_bad_ae
      $error("ldl_sfifo_v2: AE_LVL out of range 0..DEPTH-1");
    end
  endgenerate

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp, wp_nxt, rp_nxt;
  logic [CW-1:0] cnt_nxt;
  logic          wr_ok, rd_ok;

  // Acceptance uses only registered flags, so no input reaches a flag combinationally.
  always_comb begin
    wr_ok   = f.we & ~f.full  & ~f.clr;
    rd_ok   = f.re & ~f.empty & ~f.clr;
    wp_nxt  = wp;
    rp_nxt  = rp;
    cnt_nxt = f.cnt;
    if (f.clr) begin
      wp_nxt  = '0;
      rp_nxt  = '0;
      cnt_nxt = '0;
    end else begin
      if (wr_ok) wp_nxt = (wp == AW'(DEPTH - 1)) ? '0 : wp + 1'b1;
      if (rd_ok) rp_nxt = (rp == AW'(DEPTH - 1)) ? '0 : rp + 1'b1;
      cnt_nxt = f.cnt + CW'(wr_ok) - CW'(rd_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wp] <= f.din;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp       <= '0;
      rp       <= '0;
      f.cnt    <= '0;
      f.empty  <= 1'b1;
      f.full   <= 1'b0;
      f.aempty <= 1'b1;
      f.afull  <= 1'b0;
      f.ovf    <= 1'b0;
      f.udf    <= 1'b0;
      f.dout   <= '0;
      f.dvld   <= 1'b0;
    end else begin
      wp       <= wp_nxt;
      rp       <= rp_nxt;
      f.cnt    <= cnt_nxt;
      f.empty  <= (cnt_nxt == '0);
      f.full   <= (cnt_nxt == CW'(DEPTH));
      f.aempty <= (cnt_nxt <= CW'(AE_LVL));
      f.afull  <= (cnt_nxt >= CW'(AF_LVL));
      f.ovf    <= f.we & f.full  & ~f.clr;
      f.udf    <= f.re & f.empty & ~f.clr;
      if (f.clr) begin
        f.dvld <= 1'b0;
      end else if (FWFT) begin
        f.dvld <= (cnt_nxt != '0);
        // Next head is being written this cycle only when the FIFO drains to it.
        if (cnt_nxt != '0)
          f.dout <= (wr_ok && rp_nxt == wp) ? f.din : mem[rp_nxt];
      end else begin
        f.dvld <= rd_ok;
        if (rd_ok) f.dout <= mem[rp];
      end
    end
  end
endmodule

// File: tb/tb_ldl_sfifo_v2.sv
// Drives a FWFT and a registered-read FIFO (DEPTH=5) in lockstep and checks both
// every cycle against a queue model of the FIFO.
module tb_ldl_sfifo_v2;
  localparam int DEPTH = 5;
  localparam int AF    = 3;
  localparam int AE    = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ldl_sfifo_v2_if #(.DW(8), .DEPTH(DEPTH)) ia ();
  ldl_sfifo_v2_if #(.DW(8), .DEPTH(DEPTH)) ib ();

  ldl_sfifo_v2 #(.DW(8), .DEPTH(DEPTH), .FWFT(1'b1), .AF_LVL(AF), .AE_LVL(AE))
    u_a (.clk(clk), .rst(rst), .f(ia));
  ldl_sfifo_v2 #(.DW(8), .DEPTH(DEPTH), .FWFT(1'b0), .AF_LVL(AF), .AE_LVL(AE))
    u_b (.clk(clk), .rst(rst), .f(ib));

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] q[$];
  logic [7:0] m_dout_a, m_dout_b;
  logic       m_dvld_a, m_dvld_b, m_ovf, m_udf;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_dout_a = '0; m_dout_b = '0;
    m_dvld_a = 1'b0; m_dvld_b = 1'b0;
    m_ovf = 1'b0; m_udf = 1'b0;
  endtask

  task automatic model_step(input bit c, input bit w, input logic [7:0] d, input bit r);
    logic [7:0] popped;
    bit was_full, was_empty;
    if (c) begin
      q.delete();
      m_ovf = 1'b0; m_udf = 1'b0;
      m_dvld_a = 1'b0; m_dvld_b = 1'b0;
    end else begin
      was_full  = (q.size() == DEPTH);
      was_empty = (q.size() == 0);
      m_ovf = w && was_full;
      m_udf = r && was_empty;
      m_dvld_b = 1'b0;
      if (r && !was_empty) begin
        popped   = q.pop_front();
        m_dout_b = popped;
        m_dvld_b = 1'b1;
      end
      if (w && !was_full) q.push_back(d);
      m_dvld_a = (q.size() != 0);
      if (q.size() != 0) m_dout_a = q[0];
    end
  endtask

  task automatic check_all(input string ph);
    int n;
    n = q.size();
    chk({ph, ":cnt"},    32'(ia.cnt),    n);
    chk({ph, ":empty"},  32'(ia.empty),  32'(n == 0));
    chk({ph, ":full"},   32'(ia.full),   32'(n == DEPTH));
    chk({ph, ":aempty"}, 32'(ia.aempty), 32'(n <= AE));
    chk({ph, ":afull"},  32'(ia.afull),  32'(n >= AF));
    chk({ph, ":ovf"},    32'(ia.ovf),    32'(m_ovf));
    chk({ph, ":udf"},    32'(ia.udf),    32'(m_udf));
    chk({ph, ":a_dvld"}, 32'(ia.dvld),   32'(m_dvld_a));
    chk({ph, ":a_dout"}, 32'(ia.dout),   32'(m_dout_a));
    chk({ph, ":b_cnt"},  32'(ib.cnt),    n);
    chk({ph, ":b_full"}, 32'(ib.full),   32'(n == DEPTH));
    chk({ph, ":b_ovf"},  32'(ib.ovf),    32'(m_ovf));
    chk({ph, ":b_udf"},  32'(ib.udf),    32'(m_udf));
    chk({ph, ":b_dvld"}, 32'(ib.dvld),   32'(m_dvld_b));
    chk({ph, ":b_dout"}, 32'(ib.dout),   32'(m_dout_b));
  endtask

  task automatic drive(input bit c, input bit w, input logic [7:0] d, input bit r);
    ia.clr = c; ia.we = w; ia.din = d; ia.re = r;
    ib.clr = c; ib.we = w; ib.din = d; ib.re = r;
  endtask

  task automatic step(input string ph, input bit c, input bit w, input logic [7:0] d, input bit r);
    drive(c, w, d, r);
    @(posedge clk);
    model_step(c, w, d, r);
    #1;
    check_all(ph);
  endtask

  initial begin
    logic [7:0] v;
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    #2 rst = 1'b0;
    #1;
    model_reset();
    check_all("reset");
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;

    // Fill 0x11..0x55, then one rejected write.
    for (int i = 1; i <= 5; i++) step("fill", 1'b0, 1'b1, 8'(i * 8'h11), 1'b0);
    chk("fill_cnt5", 32'(ia.cnt), 5);
    chk("fill_full", 32'(ia.full), 1);
    step("ovf", 1'b0, 1'b1, 8'h66, 1'b0);
    chk("ovf_pulse", 32'(ia.ovf), 1);
    chk("ovf_cnt", 32'(ia.cnt), 5);
    for (int i = 1; i <= 5; i++) begin
      chk("fwft_head", 32'(ia.dout), 32'(i * 8'h11));
      step("drain", 1'b0, 1'b0, 8'h00, 1'b1);
      chk("rr_data", 32'(ib.dout), 32'(i * 8'h11));
    end
    chk("drain_empty", 32'(ia.empty), 1);

    // Pointer wrap with occupancy held at 2.
    step("wrap_pre", 1'b0, 1'b1, 8'hA0, 1'b0);
    step("wrap_pre", 1'b0, 1'b1, 8'hA1, 1'b0);
    for (int i = 0; i < 7; i++) begin
      step("wrap", 1'b0, 1'b1, 8'(8'hA2 + i), 1'b1);
      chk("wrap_data", 32'(ib.dout), 32'(8'hA0 + i));
      chk("wrap_cnt", 32'(ia.cnt), 2);
    end
    step("wrap_post", 1'b0, 1'b0, 8'h00, 1'b1);
    step("wrap_post", 1'b0, 1'b0, 8'h00, 1'b1);

    // Registered-read latency.
    step("rr_w", 1'b0, 1'b1, 8'h3C, 1'b0);
    step("rr_r", 1'b0, 1'b0, 8'h00, 1'b1);
    chk("rr_3c", 32'(ib.dout), 32'h3C);
    chk("rr_dvld1", 32'(ib.dvld), 1);
    step("rr_idle", 1'b0, 1'b0, 8'h00, 1'b0);
    chk("rr_dvld0", 32'(ib.dvld), 0);

    // Read+write on empty: read rejected, write accepted.
    step("emp_rw", 1'b0, 1'b1, 8'h5A, 1'b1);
    chk("emp_rw_udf", 32'(ia.udf), 1);
    chk("emp_rw_cnt", 32'(ia.cnt), 1);

    // Read+write on full: read accepted, write rejected.
    for (int i = 0; i < 4; i++) step("tofull", 1'b0, 1'b1, 8'(8'hC0 + i), 1'b0);
    step("full_rw", 1'b0, 1'b1, 8'hEE, 1'b1);
    chk("full_rw_ovf", 32'(ia.ovf), 1);
    chk("full_rw_cnt", 32'(ia.cnt), 4);

    // Flush wins over a concurrent write.
    step("to3", 1'b0, 1'b0, 8'h00, 1'b1);
    step("clr", 1'b1, 1'b1, 8'h77, 1'b0);
    chk("clr_cnt", 32'(ia.cnt), 0);
    chk("clr_ovf", 32'(ia.ovf), 0);

    // Asynchronous reset mid-burst.
    for (int i = 0; i < 3; i++) step("burst", 1'b0, 1'b1, 8'(8'h90 + i), 1'b0);
    drive(1'b0, 1'b1, 8'h99, 1'b1);
    @(negedge clk);
    #1 rst = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    @(posedge clk);
    #1 check_all("rst_hold");
    @(negedge clk);
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    rst = 1'b1;

    // Randomized traffic in phases with different write/read bias.
    for (int ph = 0; ph < 6; ph++) begin
      int pw, pr;
      pw = (ph % 3 == 0) ? 75 : (ph % 3 == 1) ? 25 : 50;
      pr = 100 - pw;
      for (int i = 0; i < 100; i++) begin
        v = 8'($urandom);
        step("rand", ($urandom_range(99) < 2), ($urandom_range(99) < pw), v,
             ($urandom_range(99) < pr));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
